dmem_bridge: RTL and testbench

Data-memory bridge between the CPU's ME stage and an external single-port data bus with variable-latency acknowledge. It turns each ME-stage load or store into one bus transaction and generates byte-lane enables. It sign- or zero-extends load data and stalls the pipeline until the transaction completes. It sits directly downstream of the `mips` core's `memwriteM`/`aluoutM`/`writedataM` outputs and produces its `readdataM` input.

---
 rtl/mips_defs_pkg.sv | 30 +++
 rtl/dmem_lane_fmt.sv | 53 +++++
 rtl/dmem_bridge.sv | 160 ++++++++++++++++
 tb/tb_dmem_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS data-memory definitions: access size encodings, bridge FSM states,
// and the alignment rule.
package mips_defs_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmemState_t;

    // The reserved size 2'b11 is treated as a word access.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF) begin
            mis = offset[0];
        end else if (size != SZ_BYTE) begin
            mis = (offset != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane logic: store byte enables and lane replication, and load lane
// extraction with sign or zero extension.
module dmem_lane_fmt
    import mips_defs_pkg::*;
(
    input  logic [1:0]      stSize,
    input  logic [1:0]      stOffset,
    input  logic [XLEN-1:0] stData,
    output logic [BE_W-1:0] stBe,
    output logic [XLEN-1:0] stWdata,
    input  logic [1:0]      ldSize,
    input  logic [1:0]      ldOffset,
    input  logic            ldSigned,
    input  logic [XLEN-1:0] ldRaw,
    output logic [XLEN-1:0] ldData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin : storeLanes
        stBe    = 4'b1111;
        stWdata = stData;
        case (stSize)
            SZ_BYTE: begin
                stBe    = 4'b0001 << stOffset;
                stWdata = {4{stData[7:0]}};
            end
            SZ_HALF: begin
                stBe    = stOffset[1] ? 4'b1100 : 4'b0011;
                stWdata = {2{stData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin : loadLanes
        case (ldOffset)
            2'd0:    byteLane = ldRaw[7:0];
            2'd1:    byteLane = ldRaw[15:8];
            2'd2:    byteLane = ldRaw[23:16];
            default: byteLane = ldRaw[31:24];
        endcase
        halfLane = ldOffset[1] ? ldRaw[31:16] : ldRaw[15:0];
        ldData   = ldRaw;
        case (ldSize)
            SZ_BYTE: ldData = {{24{ldSigned & byteLane[7]}}, byteLane};
            SZ_HALF: ldData = {{16{ldSigned & halfLane[15]}}, halfLane};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// ME-stage data-memory bridge: one bus transaction per aligned load/store, with pipeline stall.
// Optional bus-timeout abort is compiled in with DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
    import mips_defs_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memreadM,
    input  logic            memwriteM,
    input  logic [1:0]      sizeM,
    input  logic            signedM,
    input  logic [XLEN-1:0] aluoutM,
    input  logic [XLEN-1:0] writedataM,
    output logic [XLEN-1:0] readdataM,
    output logic            stallM,
    output logic            adelM,
    output logic            adesM,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack,
    output logic            bus_err
);

    dmemState_t      state;
    dmemState_t      stateNext;
    logic            access;
    logic            misaligned;
    logic            aligned;
    logic            startAcc;
    logic            ackHit;
    logic            timeoutHit;
    logic            toExpired;
    logic [1:0]      ldSize;
    logic [1:0]      ldOffset;
    logic            ldSigned;
    logic [BE_W-1:0] fmtBe;
    logic [XLEN-1:0] fmtWdata;
    logic [XLEN-1:0] fmtRdata;

    assign access     = memreadM | memwriteM;
    assign misaligned = isMisaligned(sizeM, aluoutM[1:0]);
    assign aligned    = access & ~misaligned;

    // Reset gates the combinational outputs so everything reads 0 while rst is low.
    assign adelM   = rst & access & ~memwriteM & misaligned;
    assign adesM   = rst & memwriteM & misaligned;
    assign stallM  = rst & (((state == IDLE) & aligned) | (state == BUSY));
    assign bus_req = (state == BUSY);

    dmem_lane_fmt uLaneFmt (
        .stSize   (sizeM),
        .stOffset (aluoutM[1:0]),
        .stData   (writedataM),
        .stBe     (fmtBe),
        .stWdata  (fmtWdata),
        .ldSize   (ldSize),
        .ldOffset (ldOffset),
        .ldSigned (ldSigned),
        .ldRaw    (bus_rdata),
        .ldData   (fmtRdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin : fsmNext
        stateNext  = state;
        startAcc   = 1'b0;
        ackHit     = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (aligned) begin
                    stateNext = BUSY;
                    startAcc  = 1'b1;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    stateNext = DONE;
                    ackHit    = 1'b1;
                end else if (toExpired) begin
                    stateNext  = DONE;
                    timeoutHit = 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request fields latch at the IDLE->BUSY edge and hold through the transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            ldSize    <= SZ_BYTE;
            ldOffset  <= 2'b00;
            ldSigned  <= 1'b0;
            readdataM <= '0;
        end else begin
            if (startAcc) begin
                bus_we    <= memwriteM;
                bus_addr  <= {aluoutM[XLEN-1:2], 2'b00};
                bus_be    <= fmtBe;
                bus_wdata <= fmtWdata;
                ldSize    <= sizeM;
                ldOffset  <= aluoutM[1:0];
                ldSigned  <= signedM;
            end
            if (ackHit && !bus_we) begin
                readdataM <= fmtRdata;
            end else if (timeoutHit && !bus_we) begin
                readdataM <= '0;
            end
        end
    end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] toCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            toCnt   <= '0;
            bus_err <= 1'b0;
        end else begin
            if (startAcc) begin
                toCnt <= '0;
            end else if ((state == BUSY) && !bus_ack) begin
                toCnt <= toCnt + 8'd1;
            end
            bus_err <= timeoutHit;
        end
    end

    assign toExpired = (state == BUSY) && (toCnt == TimeoutLast);
`else
    logic [7:0] unusedTimeoutLast;

    assign unusedTimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    assign toExpired         = 1'b0;
    assign bus_err           = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge; the timeout scenario runs when
// DMEM_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_dmem_bridge;
    import mips_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreadM, memwriteM, signedM;
    logic [1:0]  sizeM;
    logic [31:0] aluoutM, writedataM, readdataM;
    logic        stallM, adelM, adesM;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int vectors = 0;
    int miscompares = 0;

    // Observations gathered by runAccess
    int          obsStall, obsBusy, obsPulses, obsErr;
    logic        obsFirstReq, obsChanged, obsDone, obsAdel, obsAdes, obsWe;
    logic [31:0] obsAddr, obsWdata, obsRdata;
    logic [3:0]  obsBe;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM), .signedM(signedM),
        .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
        .stallM(stallM), .adelM(adelM), .adesM(adesM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    task automatic idleInputs();
        memreadM   = 1'b0;
        memwriteM  = 1'b0;
        sizeM      = SZ_WORD;
        signedM    = 1'b0;
        aluoutM    = 32'h0;
        writedataM = 32'h0;
        bus_ack    = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the rising edge that leaves DONE.
    task automatic runAccess(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sgn, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int ackWait);
        logic prevReq;
        prevReq = 1'b0;
        obsStall = 0; obsBusy = 0; obsPulses = 0; obsErr = 0;
        obsFirstReq = 1'b0; obsChanged = 1'b0; obsDone = 1'b0;
        obsAdel = 1'b0; obsAdes = 1'b0; obsWe = 1'b0;
        obsAddr = 32'h0; obsWdata = 32'h0; obsRdata = 32'h0; obsBe = 4'h0;
        memreadM = rd; memwriteM = wr; sizeM = sz; signedM = sgn;
        aluoutM = addr; writedataM = wdata; bus_rdata = rdata; bus_ack = 1'b0;
        for (int cyc = 0; cyc < 400 && !obsDone; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                obsFirstReq = bus_req;
                obsAdel     = adelM;
                obsAdes     = adesM;
            end
            if (bus_err) obsErr++;
            if (bus_req) begin
                obsBusy++;
                if (!prevReq) begin
                    obsPulses++;
                    obsAddr = bus_addr; obsBe = bus_be; obsWdata = bus_wdata; obsWe = bus_we;
                end else if (bus_addr !== obsAddr || bus_be !== obsBe ||
                             bus_wdata !== obsWdata || bus_we !== obsWe) begin
                    obsChanged = 1'b1;
                end
                bus_ack = (obsBusy > ackWait);
            end else begin
                bus_ack = 1'b0;
            end
            prevReq = bus_req;
            if (stallM) begin
                obsStall++;
            end else begin
                obsDone  = 1'b1;
                obsRdata = readdataM;
            end
        end
        @(posedge clk);
        #1;
        idleInputs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idleInputs();
        bus_rdata = 32'h0;
        memreadM = 1'b1;
        aluoutM  = 32'h40;
        #2;
        vectors++;
        if ({readdataM, bus_addr, bus_wdata, bus_be, bus_req, bus_we, stallM, bus_err} !== 104'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rd=%h addr=%h wd=%h be=%b req=%b we=%b stall=%b err=%b want all 0",
                     readdataM, bus_addr, bus_wdata, bus_be, bus_req, bus_we, stallM, bus_err);
        end
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus_req, stallM, readdataM} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_release: got req=%b stall=%b rd=%h want 0 0 0", bus_req, stallM, readdataM);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_byte();
        runAccess(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0);
        vectors++;
        if (obsBe !== 4'b1000) begin miscompares++; $display("FAIL sb_be: got %b want 1000", obsBe); end
        vectors++;
        if (obsWdata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obsWdata); end
        vectors++;
        if (obsAddr !== 32'h100) begin miscompares++; $display("FAIL sb_addr: got %h want 00000100", obsAddr); end
        vectors++;
        if (obsWe !== 1'b1) begin miscompares++; $display("FAIL sb_we: got %b want 1", obsWe); end
        vectors++;
        if (obsStall != 2 || !obsDone) begin miscompares++; $display("FAIL sb_stall: got %0d done=%b want 2 done=1", obsStall, obsDone); end
        vectors++;
        if (obsFirstReq !== 1'b0 || obsPulses != 1) begin
            miscompares++; $display("FAIL sb_req: got first=%b pulses=%0d want 0 1", obsFirstReq, obsPulses);
        end
    endtask

    task automatic test_load_half();
        runAccess(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h202, 32'h0, 32'h80011234, 3);
        vectors++;
        if (obsRdata !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_data: got %h want ffff8001", obsRdata); end
        vectors++;
        if (obsStall != 5) begin miscompares++; $display("FAIL lh_stall: got %0d want 5", obsStall); end
        vectors++;
        if (obsBe !== 4'b1100 || obsWe !== 1'b0 || obsAddr !== 32'h200) begin
            miscompares++; $display("FAIL lh_req: got be=%b we=%b addr=%h want 1100 0 00000200", obsBe, obsWe, obsAddr);
        end
        runAccess(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h202, 32'h0, 32'h80011234, 3);
        vectors++;
        if (obsRdata !== 32'h00008001) begin miscompares++; $display("FAIL lhu_data: got %h want 00008001", obsRdata); end
        vectors++;
        if (obsStall != 5) begin miscompares++; $display("FAIL lhu_stall: got %0d want 5", obsStall); end
    endtask

    task automatic test_load_byte();
        runAccess(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h301, 32'h0, 32'h0000F200, 1);
        vectors++;
        if (obsRdata !== 32'hFFFFFFF2) begin miscompares++; $display("FAIL lb_data: got %h want fffffff2", obsRdata); end
        vectors++;
        if (obsStall != 3) begin miscompares++; $display("FAIL lb_stall: got %0d want 3", obsStall); end
        runAccess(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h303, 32'h0, 32'h9A000000, 0);
        vectors++;
        if (obsRdata !== 32'h0000009A) begin miscompares++; $display("FAIL lbu_data: got %h want 0000009a", obsRdata); end
        vectors++;
        if (obsBe !== 4'b1000) begin miscompares++; $display("FAIL lbu_be: got %b want 1000", obsBe); end
    endtask

    task automatic test_store_half_word();
        runAccess(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234BEEF, 32'hFFFFFFFF, 0);
        vectors++;
        if (obsBe !== 4'b1100 || obsWdata !== 32'hBEEFBEEF || obsAddr !== 32'h10) begin
            miscompares++; $display("FAIL sh_req: got be=%b wd=%h addr=%h want 1100 beefbeef 00000010", obsBe, obsWdata, obsAddr);
        end
        vectors++;
        if (obsRdata !== 32'h0000009A) begin miscompares++; $display("FAIL sh_keep_rdata: got %h want 0000009a", obsRdata); end
        // Reserved size with both strobes high: word store
        runAccess(1'b1, 1'b1, 2'b11, 1'b0, 32'h24, 32'hCAFEF00D, 32'h0, 0);
        vectors++;
        if (obsBe !== 4'b1111 || obsWdata !== 32'hCAFEF00D || obsWe !== 1'b1 || obsAddr !== 32'h24) begin
            miscompares++;
            $display("FAIL sw_req: got be=%b wd=%h we=%b addr=%h want 1111 cafef00d 1 00000024", obsBe, obsWdata, obsWe, obsAddr);
        end
        vectors++;
        if (obsRdata !== 32'h0000009A) begin miscompares++; $display("FAIL sw_keep_rdata: got %h want 0000009a", obsRdata); end
    endtask

    task automatic test_misaligned();
        logic sawBad;
        sawBad = 1'b0;
        memreadM = 1'b1; sizeM = SZ_WORD; aluoutM = 32'h6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b0 || stallM !== 1'b0 || adelM !== 1'b1 || adesM !== 1'b0) sawBad = 1'b1;
        end
        vectors++;
        if (sawBad) begin
            miscompares++;
            $display("FAIL lw_misaligned: got req=%b stall=%b adel=%b ades=%b want 0 0 1 0", bus_req, stallM, adelM, adesM);
        end
        @(posedge clk);
        #1;
        idleInputs();
        runAccess(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h5555, 32'h0, 0);
        vectors++;
        if (obsAdes !== 1'b1 || obsAdel !== 1'b0 || obsStall != 0 || obsPulses != 0) begin
            miscompares++;
            $display("FAIL sh_misaligned: got ades=%b adel=%b stall=%0d pulses=%0d want 1 0 0 0", obsAdes, obsAdel, obsStall, obsPulses);
        end
    endtask

    task automatic test_back_to_back();
        runAccess(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344, 32'h0, 2);
        vectors++;
        if (obsChanged !== 1'b0 || obsPulses != 1 || obsBusy != 3) begin
            miscompares++;
            $display("FAIL b2b_store_hold: got changed=%b pulses=%0d busy=%0d want 0 1 3", obsChanged, obsPulses, obsBusy);
        end
        vectors++;
        if (obsStall != 4 || obsWdata !== 32'h11223344) begin
            miscompares++; $display("FAIL b2b_store: got stall=%0d wd=%h want 4 11223344", obsStall, obsWdata);
        end
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, 32'h55667788, 0);
        vectors++;
        if (obsFirstReq !== 1'b0 || obsPulses != 1) begin
            miscompares++; $display("FAIL b2b_gap: got first_req=%b pulses=%0d want 0 1", obsFirstReq, obsPulses);
        end
        vectors++;
        if (obsRdata !== 32'h55667788 || obsStall != 2 || obsAddr !== 32'h44) begin
            miscompares++;
            $display("FAIL b2b_load: got rd=%h stall=%0d addr=%h want 55667788 2 00000044", obsRdata, obsStall, obsAddr);
        end
    endtask

    task automatic test_reset_mid();
        memreadM = 1'b1; sizeM = SZ_WORD; aluoutM = 32'h80; bus_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy: got req=%b want 1", bus_req); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus_req !== 1'b0 || stallM !== 1'b0 || bus_addr !== 32'h0 || readdataM !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_async: got req=%b stall=%b addr=%h rd=%h want 0 0 0 0", bus_req, stallM, bus_addr, readdataM);
        end
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        runAccess(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h44, 32'h0BADF00D, 32'h0, 0);
        vectors++;
        if (obsFirstReq !== 1'b0 || obsStall != 2 || obsPulses != 1 || obsAddr !== 32'h44) begin
            miscompares++;
            $display("FAIL rstmid_next: got first=%b stall=%0d pulses=%0d addr=%h want 0 2 1 00000044",
                     obsFirstReq, obsStall, obsPulses, obsAddr);
        end
    endtask

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        logic lateErr;
        lateErr = 1'b0;
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 0);
        vectors++;
        if (obsRdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL to_preload: got %h want deadbeef", obsRdata); end
        runAccess(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h84, 32'h0, 32'h12345678, 1000);
        vectors++;
        if (!obsDone || obsBusy != 4 || obsStall != 5) begin
            miscompares++; $display("FAIL to_release: got done=%b busy=%0d stall=%0d want 1 4 5", obsDone, obsBusy, obsStall);
        end
        vectors++;
        if (obsErr != 1 || obsRdata !== 32'h0) begin
            miscompares++; $display("FAIL to_err: got err_cycles=%0d rd=%h want 1 00000000", obsErr, obsRdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_err !== 1'b0) lateErr = 1'b1;
        end
        vectors++;
        if (lateErr) begin miscompares++; $display("FAIL to_single_pulse: got extra bus_err want none"); end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_load_byte();
        test_store_half_word();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
